strassen_mm2x2_pipe: RTL

Pipelined, parametrised 2x2 signed matrix multiplier using Strassen's seven-product decomposition, successor to the fixed-width single-shot multiplier in the accelerator datapath. It accepts one operand pair per cycle over a valid/ready handshake, supports matrix-matrix and matrix-vector modes per beat, and accumulates products across a burst with saturation. It sits between the operand fetch stage and the result write-back buffer, and stalls fully under downstream backpressure.

---
 rtl/strassen_mm2x2_pipe.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/strassen_mm2x2_pipe.sv
// strassen_mm2x2_pipe: pipelined 2x2 signed matrix multiplier built on
// Strassen's seven-product form. Four register stages (pre-add, multiply,
// post-add, accumulate/output) share one global enable, so the whole pipe
// freezes while a result waits for the downstream consumer.
module strassen_mm2x2_pipe #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 40,
  parameter int BEATW     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATAWIDTH-1:0]  in_a,
  input  logic [4*DATAWIDTH-1:0]  in_b,
  input  logic                    in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*ACCWIDTH-1:0]   out_c,
  output logic                    out_ovf,
  output logic [BEATW-1:0]        out_beats
);

  localparam int DW = DATAWIDTH;
  localparam int TW = DW + 1;       // pre-add width
  localparam int MW = 2 * DW + 2;   // product width
  localparam int CW = 2 * DW + 4;   // post-add width
  localparam int AW = ACCWIDTH;
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // The accumulator must hold at least one full post-add result.
  generate
    if (ACCWIDTH < 2 * DATAWIDTH + 4) begin : g_accw_check
      $error("strassen_mm2x2_pipe: ACCWIDTH must be >= 2*DATAWIDTH+4");
    end
  endgenerate

  logic                 en;
  logic signed [DW-1:0] a [4];
  logic signed [DW-1:0] b [4];

  logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
  logic signed [TW-1:0] t_q [7];
  logic signed [TW-1:0] t_d [7];
  logic signed [TW-1:0] s_q [7];
  logic signed [TW-1:0] s_d [7];

  logic                 s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_mode_q, s2_mode_d;
  logic signed [MW-1:0] m_q [7];
  logic signed [MW-1:0] m_d [7];

  logic                 s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic signed [CW-1:0] c_q [4];
  logic signed [CW-1:0] c_d [4];

  logic signed [AW-1:0] acc_q [4];
  logic signed [AW-1:0] acc_d [4];
  logic signed [AW-1:0] sat_sum [4];
  logic [3:0]           clamp;
  logic                 ovf_q, ovf_d, ovf_new;
  logic [BEATW-1:0]     beats_q, beats_d, beats_new;

  logic                 out_valid_q, out_valid_d;
  logic [AW-1:0]        out_c_q [4];
  logic [AW-1:0]        out_c_d [4];
  logic                 out_ovf_q, out_ovf_d;
  logic [BEATW-1:0]     out_beats_q, out_beats_d;

  // A pending result that is not being taken freezes every stage.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign out_beats = out_beats_q;

  // Per-element saturating accumulate and output packing.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_elem
      logic signed [AW:0] sum;
      assign sum          = (AW+1)'(acc_q[gi]) + (AW+1)'(c_q[gi]);
      assign clamp[gi]    = sum[AW] != sum[AW-1];
      assign sat_sum[gi]  = !clamp[gi] ? sum[AW-1:0] : (sum[AW] ? ACC_MIN : ACC_MAX);
      assign out_c[gi*AW +: AW] = out_c_q[gi];
    end
  endgenerate

  // Unpack operands; matrix-vector mode replicates B column 0 into column 1.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k] = in_a[k*DW +: DW];
      b[k] = in_b[k*DW +: DW];
    end
    if (in_mode) begin
      b[1] = b[0];
      b[3] = b[2];
    end
  end

  // Stage 1: Strassen pre-adds; terms unused by matrix-vector mode are zeroed.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    t_d        = t_q;
    s_d        = s_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_last_d  = in_last;
      s1_mode_d  = in_mode;
      t_d[0] = TW'(a[0]) + TW'(a[3]);
      t_d[1] = TW'(a[2]) + TW'(a[3]);
      t_d[2] = TW'(a[0]);
      t_d[3] = TW'(a[3]);
      t_d[4] = TW'(a[0]) + TW'(a[1]);
      t_d[5] = TW'(a[2]) - TW'(a[0]);
      t_d[6] = TW'(a[1]) - TW'(a[3]);
      s_d[0] = TW'(b[0]) + TW'(b[3]);
      s_d[1] = TW'(b[0]);
      s_d[2] = TW'(b[1]) - TW'(b[3]);
      s_d[3] = TW'(b[2]) - TW'(b[0]);
      s_d[4] = TW'(b[3]);
      s_d[5] = TW'(b[0]) + TW'(b[1]);
      s_d[6] = TW'(b[2]) + TW'(b[3]);
      if (in_mode) begin
        t_d[0] = '0;
        t_d[5] = '0;
        t_d[6] = '0;
        s_d[0] = '0;
        s_d[5] = '0;
        s_d[6] = '0;
      end
    end
  end

  // Stage 2: the seven products.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_mode_d  = s2_mode_q;
    m_d        = m_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_mode_d  = s1_mode_q;
      for (int k = 0; k < 7; k++) begin
        m_d[k] = MW'(t_q[k]) * MW'(s_q[k]);
      end
    end
  end

  // Stage 3: recombine products into the four C elements.
  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    c_d        = c_q;
    if (en) begin
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      if (s2_mode_q) begin
        c_d[0] = CW'(m_q[2]) + CW'(m_q[4]);
        c_d[1] = '0;
        c_d[2] = CW'(m_q[1]) + CW'(m_q[3]);
        c_d[3] = '0;
      end else begin
        c_d[0] = CW'(m_q[0]) + CW'(m_q[3]) - CW'(m_q[4]) + CW'(m_q[6]);
        c_d[1] = CW'(m_q[2]) + CW'(m_q[4]);
        c_d[2] = CW'(m_q[1]) + CW'(m_q[3]);
        c_d[3] = CW'(m_q[0]) - CW'(m_q[1]) + CW'(m_q[2]) + CW'(m_q[5]);
      end
    end
  end

  // Stage 4: accumulate the group; a last beat publishes and clears it.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_ovf_d   = out_ovf_q;
    out_beats_d = out_beats_q;
    ovf_new     = ovf_q | (|clamp);
    beats_new   = (beats_q == '1) ? beats_q : beats_q + BEATW'(1);
    if (en) begin
      out_valid_d = 1'b0;
      if (s3_valid_q) begin
        if (s3_last_q) begin
          out_valid_d = 1'b1;
          for (int k = 0; k < 4; k++) begin
            out_c_d[k] = sat_sum[k];
            acc_d[k]   = '0;
          end
          out_ovf_d   = ovf_new;
          out_beats_d = beats_new;
          ovf_d       = 1'b0;
          beats_d     = '0;
        end else begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = sat_sum[k];
          end
          ovf_d   = ovf_new;
          beats_d = beats_new;
        end
      end
    end
  end

  // State register for all stages; reset discards any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_mode_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      ovf_q       <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
      for (int k = 0; k < 7; k++) begin
        t_q[k] <= '0;
        s_q[k] <= '0;
        m_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        c_q[k]     <= '0;
        acc_q[k]   <= '0;
        out_c_q[k] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_mode_q   <= s2_mode_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      ovf_q       <= ovf_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_beats_q <= out_beats_d;
      t_q         <= t_d;
      s_q         <= s_d;
      m_q         <= m_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      out_c_q     <= out_c_d;
    end
  end

endmodule
